// File: rtl/msp430_pkg.sv
// rtl/msp430_pkg.sv - shared FSM encoding and vector constants for the interrupt controller
package msp430_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFFE0;
  localparam logic [15:0] NMI_VEC_DEFAULT  = 16'hFFFC;
  localparam logic [3:0]  NMI_NUM          = 4'hF;

endpackage

// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - pipeline/decoder side bus of the interrupt controller
interface int_ctrl_if #(
  parameter int NUM_IRQ = 8
) ();

  logic               GIE;
  logic               en_we;
  logic [NUM_IRQ-1:0] en_wdata;
  logic               int_ack;
  logic               reti;
  logic               int_req;
  logic [15:0]        int_vec;
  logic [3:0]         int_num;
  logic [NUM_IRQ-1:0] int_en;
  logic [NUM_IRQ-1:0] pending;
  logic               busy;

  modport master (
    input  GIE, en_we, en_wdata, int_ack, reti,
    output int_req, int_vec, int_num, int_en, pending, busy
  );

  modport slave (
    output GIE, en_we, en_wdata, int_ack, reti,
    input  int_req, int_vec, int_num, int_en, pending, busy
  );

endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - 2-flop synchronizer plus rising-edge detector, one pulse per rise
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Zero reset makes an input already high at release look like one rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-triggered interrupt controller with NMI, fixed priority and a
// non-nesting IDLE/REQ/SERVICE handshake with the instruction decoder
module int_ctrl
  import msp430_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT,
  parameter logic [15:0] NMI_VEC  = NMI_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  int_ctrl_if.master         bus
);

  int_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] int_en_q, int_en_d;
  logic               nmi_flag_q, nmi_flag_d;
  logic               sel_nmi_q, sel_nmi_d;
  logic [15:0]        vec_q, vec_d;
  logic [3:0]         num_q, num_d;

  logic [NUM_IRQ-1:0] irq_edge;
  logic               nmi_edge;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               cand_valid;
  logic [3:0]         cand_idx;
  logic               ack_take;

  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (irq_in),
    .edge_o  (irq_edge)
  );

  irq_sync #(.WIDTH(1)) u_nmi_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (nmi_in),
    .edge_o  (nmi_edge)
  );

  // Ascending scan so the last hit is the highest enabled index.
  always_comb begin
    masked     = pending_q & int_en_q;
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (masked[i]) begin
        cand_valid = 1'b1;
        cand_idx   = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (nmi_flag_q || (bus.GIE && cand_valid)) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.int_ack)                   state_d = ST_SERVICE;
        else if (!sel_nmi_q && !bus.GIE)   state_d = ST_IDLE;
      end
      ST_SERVICE: if (bus.reti) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.int_req = (state_q == ST_REQ);
    bus.busy    = (state_q == ST_SERVICE);
    bus.int_vec = vec_q;
    bus.int_num = num_q;
    bus.int_en  = int_en_q;
    bus.pending = pending_q;
  end

  // New edges are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    ack_take = (state_q == ST_REQ) && bus.int_ack;
    clr_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_mask[i] = ack_take && !sel_nmi_q && (num_q == 4'(i));
    end
    pending_d  = (pending_q & ~clr_mask) | irq_edge;
    nmi_flag_d = (nmi_flag_q & ~(ack_take & sel_nmi_q)) | nmi_edge;
    int_en_d   = bus.en_we ? bus.en_wdata : int_en_q;

    sel_nmi_d = sel_nmi_q;
    vec_d     = vec_q;
    num_d     = num_q;
    if (state_q == ST_IDLE && state_d == ST_REQ) begin
      sel_nmi_d = nmi_flag_q;
      vec_d     = nmi_flag_q ? NMI_VEC : VEC_BASE + {11'd0, cand_idx, 1'b0};
      num_d     = nmi_flag_q ? NMI_NUM : cand_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      int_en_q   <= '0;
      nmi_flag_q <= 1'b0;
      sel_nmi_q  <= 1'b0;
      vec_q      <= '0;
      num_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      int_en_q   <= int_en_d;
      nmi_flag_q <= nmi_flag_d;
      sel_nmi_q  <= sel_nmi_d;
      vec_q      <= vec_d;
      num_q      <= num_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl with an expected-vector scoreboard
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       nmi_in;
  int         checks = 0;
  int         errors = 0;
  logic [19:0] exp_q[$];

  int_ctrl_if #(.NUM_IRQ(8)) bus ();

  int_ctrl #(.NUM_IRQ(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .nmi_in (nmi_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] vec, input logic [3:0] num);
    exp_q.push_back({vec, num});
  endtask

  task automatic pop_chk();
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=request expected=none");
    end else begin
      e = exp_q.pop_front();
      chk("int_vec", 32'(bus.int_vec), 32'(e[19:4]));
      chk("int_num", 32'(bus.int_num), 32'(e[3:0]));
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (bus.int_req !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(bus.int_req), 32'd1);
    if (bus.int_req === 1'b1) pop_chk();
  endtask

  task automatic ack_and_reti();
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    bus.reti    = 1'b1; tick(1); bus.reti    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; nmi_in = 1'b0;
    bus.GIE = 1'b0; bus.en_we = 1'b0; bus.en_wdata = '0;
    bus.int_ack = 1'b0; bus.reti = 1'b0;
    tick(2);
    chk("rst_int_req", 32'(bus.int_req), 0);
    chk("rst_busy",    32'(bus.busy),    0);
    chk("rst_int_vec", 32'(bus.int_vec), 0);
    chk("rst_int_num", 32'(bus.int_num), 0);
    chk("rst_int_en",  32'(bus.int_en),  0);
    chk("rst_pending", 32'(bus.pending), 0);
    rst = 1'b1;
    tick(1);

    // Disabled line still latches pending; enabling it raises the request.
    bus.GIE = 1'b1; irq_in = 8'h20;
    tick(2);
    chk("sync_latency_2", 32'(bus.pending), 32'h00);
    tick(1);
    chk("sync_latency_3", 32'(bus.pending), 32'h20);
    irq_in = '0;
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("ack_idle_ignored", 32'(bus.busy), 0);
    tick(1);
    chk("masked_no_req", 32'(bus.int_req), 0);
    bus.en_we = 1'b1; bus.en_wdata = 8'h20;
    push_exp(16'hFFEA, 4'd5);
    tick(1);
    bus.en_we = 1'b0;
    chk("en_loaded", 32'(bus.int_en), 32'h20);
    chk("req_after_en_pre", 32'(bus.int_req), 0);
    tick(1);
    chk("req_after_en", 32'(bus.int_req), 1);
    pop_chk();
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("svc_busy",    32'(bus.busy),    1);
    chk("svc_req_low", 32'(bus.int_req), 0);
    chk("svc_cleared", 32'(bus.pending), 0);
    bus.reti = 1'b1; tick(1); bus.reti = 1'b0;
    chk("reti_idle", 32'(bus.busy), 0);

    // Two simultaneous lines: higher index first.
    bus.en_we = 1'b1; bus.en_wdata = 8'hFF; tick(1); bus.en_we = 1'b0;
    irq_in = 8'h42;
    push_exp(16'hFFEC, 4'd6);
    push_exp(16'hFFE2, 4'd1);
    tick(3);
    irq_in = '0;
    wait_req(4);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("prio_pending_after_ack", 32'(bus.pending), 32'h02);
    bus.reti = 1'b1; tick(1); bus.reti = 1'b0;
    wait_req(3);
    ack_and_reti();

    // NMI overrides GIE=0.
    bus.GIE = 1'b0; irq_in = 8'h01;
    tick(3); irq_in = '0; tick(1);
    chk("gie0_no_req",  32'(bus.int_req), 0);
    chk("gie0_pending", 32'(bus.pending), 32'h01);
    nmi_in = 1'b1;
    push_exp(16'hFFFC, 4'hF);
    tick(3);
    chk("nmi_pre_req", 32'(bus.int_req), 0);
    tick(1);
    chk("nmi_req", 32'(bus.int_req), 1);
    pop_chk();
    nmi_in = 1'b0;
    ack_and_reti();
    chk("nmi_keeps_mask_pending", 32'(bus.pending), 32'h01);

    // GIE withdrawn during REQ: back to IDLE with pending kept.
    irq_in = 8'h08; tick(3); irq_in = '0;
    bus.GIE = 1'b1;
    push_exp(16'hFFE6, 4'd3);
    wait_req(2);
    bus.GIE = 1'b0; tick(1);
    chk("gie_drop_req",     32'(bus.int_req), 0);
    chk("gie_drop_pending", 32'(bus.pending), 32'h09);
    bus.GIE = 1'b1;
    push_exp(16'hFFE6, 4'd3);
    wait_req(2);
    ack_and_reti();
    push_exp(16'hFFE0, 4'd0);
    wait_req(2);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;

    // Reset asserted in SERVICE with pending=0x81.
    irq_in = 8'h81; tick(3); irq_in = '0;
    chk("no_nest_busy",    32'(bus.busy),    1);
    chk("no_nest_pending", 32'(bus.pending), 32'h81);
    rst = 1'b0;
    #1;
    chk("async_rst_req",     32'(bus.int_req), 0);
    chk("async_rst_busy",    32'(bus.busy),    0);
    chk("async_rst_vec",     32'(bus.int_vec), 0);
    chk("async_rst_num",     32'(bus.int_num), 0);
    chk("async_rst_en",      32'(bus.int_en),  0);
    chk("async_rst_pending", 32'(bus.pending), 0);
    @(negedge clk);
    rst = 1'b1;
    tick(4);
    chk("post_rst_no_req",  32'(bus.int_req), 0);
    chk("post_rst_pending", 32'(bus.pending), 0);

    // Input high across reset release counts as a single edge.
    rst = 1'b0; irq_in = 8'h10; tick(1); rst = 1'b1;
    tick(3);
    chk("high_at_release", 32'(bus.pending), 32'h10);
    tick(3);
    chk("high_single_edge", 32'(bus.pending), 32'h10);
    bus.en_we = 1'b1; bus.en_wdata = 8'h10; tick(1); bus.en_we = 1'b0;
    push_exp(16'hFFE8, 4'd4);
    wait_req(3);
    ack_and_reti();
    irq_in = '0;

    // Ack coincides with a fresh edge on the selected line: set wins.
    bus.en_we = 1'b1; bus.en_wdata = 8'hFF; irq_in = 8'h04;
    tick(1); bus.en_we = 1'b0;
    tick(2); irq_in = '0;
    push_exp(16'hFFE4, 4'd2);
    wait_req(2);
    tick(3);
    chk("req_held", 32'(bus.int_req), 1);
    chk("vec_held", 32'(bus.int_vec), 32'hFFE4);
    irq_in = 8'h04; tick(2);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("ack_edge_busy",    32'(bus.busy),    1);
    chk("ack_edge_pending", 32'(bus.pending), 32'h04);
    irq_in = '0;
    bus.reti = 1'b1; tick(1); bus.reti = 1'b0;
    push_exp(16'hFFE4, 4'd2);
    wait_req(3);
    ack_and_reti();
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
